// File: rtl/console_tx_unit.sv
// Character FIFO feeding a start/data/stop serial transmitter.
// Accepts up to PUSH_LANES characters per cycle. Lane 0 sits in the MSBs and is sent first.
module console_tx_unit #(
  parameter int CHAR_W       = 7,
  parameter int DEPTH        = 16,
  parameter int PUSH_LANES   = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push_valid,
  input  logic [PUSH_LANES*CHAR_W-1:0]     push_chars,
  input  logic [$clog2(PUSH_LANES+1)-1:0]  push_count,
  output logic                             push_ready,
  input  logic                             clear_ovf,
  output logic                             tx,
  output logic                             busy,
  output logic [$clog2(DEPTH+1)-1:0]       level,
  output logic                             overflow
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(PUSH_LANES+1);
  localparam int LVL_W    = $clog2(DEPTH+1);
  localparam int BAUD_MAX = STOP_BITS * CLKS_PER_BIT;
  localparam int BAUD_W   = (BAUD_MAX > 1) ? $clog2(BAUD_MAX) : 1;
  localparam int BIT_W    = $clog2(CHAR_W);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr_reg, rptr_reg;
  logic [LVL_W-1:0]  level_reg, level_next, free_slots;
  logic [CNT_W-1:0]  cnt_eff;
  logic              push_req, push_acc, push_rej, pop;
  logic              overflow_reg, tx_reg, tx_next, busy_reg;
  state_t            state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [CHAR_W-1:0] shift_reg, shift_next;

  logic [CHAR_W-1:0] lane      [PUSH_LANES];
  logic [PTR_W-1:0]  lane_addr [PUSH_LANES];
  logic              lane_we   [PUSH_LANES];

  // Oversized counts are clamped; room is judged on start-of-cycle occupancy only.
  assign cnt_eff    = (push_count > CNT_W'(PUSH_LANES)) ? CNT_W'(PUSH_LANES) : push_count;
  assign free_slots = LVL_W'(DEPTH) - level_reg;
  assign push_ready = free_slots >= LVL_W'(cnt_eff);
  assign push_req   = push_valid && (cnt_eff != '0);
  assign push_acc   = push_req && push_ready;
  assign push_rej   = push_req && !push_ready;

  genvar gi;
  generate
    for (gi = 0; gi < PUSH_LANES; gi++) begin : g_lane
      assign lane[gi]      = push_chars[(PUSH_LANES-gi)*CHAR_W-1 -: CHAR_W];
      assign lane_addr[gi] = wptr_reg + PTR_W'(gi);
      assign lane_we[gi]   = push_acc && (CNT_W'(gi) < cnt_eff);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_LANES; i++) begin
      if (lane_we[i]) mem[lane_addr[i]] <= lane[i];
    end
  end

  // tx_next is the line value for the state being entered, keeping tx registered.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (level_reg != '0) begin
          pop        = 1'b1;
          shift_next = mem[rptr_reg];
          state_next = START;
          baud_next  = '0;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_reg == BAUD_W'(CLKS_PER_BIT-1)) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_reg == BAUD_W'(CLKS_PER_BIT-1)) begin
          baud_next = '0;
          if (bit_reg == BIT_W'(CHAR_W-1)) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_reg + BIT_W'(1);
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_reg == BAUD_W'(BAUD_MAX-1)) begin
          baud_next = '0;
          if (level_reg != '0) begin
            pop        = 1'b1;
            shift_next = mem[rptr_reg];
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign level_next = level_reg + (push_acc ? LVL_W'(cnt_eff) : LVL_W'(0)) - LVL_W'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= (state_next != IDLE) || (level_next != '0);
      wptr_reg  <= wptr_reg + (push_acc ? PTR_W'(cnt_eff) : PTR_W'(0));
      rptr_reg  <= rptr_reg + PTR_W'(pop);
      level_reg <= level_next;
      if (push_rej)       overflow_reg <= 1'b1;
      else if (clear_ovf) overflow_reg <= 1'b0;
    end
  end

  assign tx       = tx_reg;
  assign busy     = busy_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_console_tx_unit.sv
// Bench for console_tx_unit. A queue plus a frame-offset reference model predicts tx, level, busy and overflow on every cycle.
// The scenario tasks check the specific behaviours.
module tb_console_tx_unit;

  localparam int CHAR_W       = 7;
  localparam int DEPTH        = 16;
  localparam int PUSH_LANES   = 4;
  localparam int CLKS_PER_BIT = 4;
  localparam int STOP_BITS    = 1;
  localparam int CNT_W        = $clog2(PUSH_LANES+1);
  localparam int LVL_W        = $clog2(DEPTH+1);
  localparam int LANES_W      = PUSH_LANES*CHAR_W;
  localparam int FRAME        = (1+CHAR_W+STOP_BITS)*CLKS_PER_BIT;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               push_valid = 1'b0;
  logic [LANES_W-1:0] push_chars = '0;
  logic [CNT_W-1:0]   push_count = '0;
  logic               clear_ovf = 1'b0;
  logic               push_ready, tx, busy, overflow;
  logic [LVL_W-1:0]   level;

  int errors = 0;
  int checks = 0;

  console_tx_unit #(
    .CHAR_W(CHAR_W), .DEPTH(DEPTH), .PUSH_LANES(PUSH_LANES),
    .CLKS_PER_BIT(CLKS_PER_BIT), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_chars(push_chars),
    .push_count(push_count), .push_ready(push_ready), .clear_ovf(clear_ovf),
    .tx(tx), .busy(busy), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: queued characters plus the cycle offset within the current frame.
  logic [CHAR_W-1:0] m_q[$];
  logic [CHAR_W-1:0] m_cur = '0;
  int                m_t = -1;
  logic              m_ovf = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    int c, sz;
    logic pop_now;
    if (reset) begin
      m_q.delete();
      m_t   = -1;
      m_ovf = 1'b0;
    end else begin
      c  = (int'(push_count) > PUSH_LANES) ? PUSH_LANES : int'(push_count);
      sz = m_q.size();
      pop_now = (m_t < 0 || m_t == FRAME-1) && sz != 0;
      if (pop_now) begin
        m_cur = m_q.pop_front();
        m_t   = 0;
      end else if (m_t == FRAME-1) begin
        m_t = -1;
      end else if (m_t >= 0) begin
        m_t++;
      end
      if (push_valid && c != 0 && (DEPTH - sz) < c) begin
        m_ovf = 1'b1;
      end else begin
        if (push_valid && c != 0)
          for (int i = 0; i < c; i++) m_q.push_back(push_chars[(PUSH_LANES-1-i)*CHAR_W +: CHAR_W]);
        if (clear_ovf) m_ovf = 1'b0;
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (m_t < 0) return 1'b1;
    b = m_t / CLKS_PER_BIT;
    if (b == 0) return 1'b0;
    if (b <= CHAR_W) return m_cur[b-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      checks++;
      if (tx !== exp_tx() || level !== LVL_W'(m_q.size()) ||
          busy !== ((m_t >= 0) || (m_q.size() != 0)) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL model t=%0t tx=%b/%b level=%0d/%0d busy=%b/%b ovf=%b/%b (actual/required)",
                 $time, tx, exp_tx(), level, m_q.size(), busy, (m_t >= 0) || (m_q.size() != 0),
                 overflow, m_ovf);
      end
    end
  end

  function automatic logic [LANES_W-1:0] rnd_chars();
    return LANES_W'($urandom);
  endfunction

  task automatic drive(input logic v, input int cnt, input logic [LANES_W-1:0] ch, input logic clr);
    push_valid = v;
    push_count = CNT_W'(cnt);
    push_chars = ch;
    clear_ovf  = clr;
    #1;
    if (v) $display("push count=%0d chars=%h clear=%b ready=%b level=%0d", cnt, ch, clr, push_ready, level);
  endtask

  task automatic idle();
    push_valid = 1'b0;
    push_count = '0;
    clear_ovf  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n = 0;
    while (busy === 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || level !== '0 || busy !== 1'b0 || push_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d tx=%b level=%0d busy=%b ready=%b, required 1 0 0 1",
                 n, tx, level, busy, push_ready);
      end
    end
  endtask

  task automatic test_single();
    logic [8:0] frame;
    frame = 9'b1_1000001_0;
    drive(1'b1, 1, {7'h41, 21'($urandom)}, 1'b0);
    checks++;
    if (push_ready !== 1'b1) begin errors++; $display("FAIL single_ready ready=%b required 1", push_ready); end
    @(negedge clk);
    idle();
    checks++;
    if (level !== LVL_W'(1) || tx !== 1'b1) begin
      errors++; $display("FAIL single_accept level=%0d tx=%b, required 1 1", level, tx);
    end
    for (int n = 0; n < FRAME; n++) begin
      @(negedge clk);
      checks++;
      if (tx !== frame[n/CLKS_PER_BIT] || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_frame offset=%0d tx=%b busy=%b, required %b 1", n, tx, busy, frame[n/CLKS_PER_BIT]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL single_end busy=%b tx=%b, required 0 1", busy, tx);
    end
  endtask

  task automatic test_multi_lane();
    drive(1'b1, 3, {7'h48, 7'h69, 7'h21, 7'h00}, 1'b0);
    @(negedge clk);
    idle();
    checks++;
    if (level !== LVL_W'(3)) begin errors++; $display("FAIL multi_level level=%0d required 3", level); end
    for (int n = 0; n < 3*FRAME; n++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL multi_gap cycle=%0d busy=%b required 1", n, busy); end
      if (n % FRAME == 0) begin
        checks++;
        if (tx !== 1'b0 || level !== LVL_W'(2 - n/FRAME)) begin
          errors++;
          $display("FAIL multi_pop frame=%0d tx=%b level=%0d, required 0 %0d", n/FRAME, tx, level, 2 - n/FRAME);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL multi_end busy=%b required 0", busy); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4, rnd_chars(), 1'b0);
      checks++;
      if (push_ready !== 1'b1) begin errors++; $display("FAIL fill_ready push=%0d ready=%b required 1", i, push_ready); end
      @(negedge clk);
    end
    idle();
    checks++;
    if (level !== LVL_W'(15)) begin errors++; $display("FAIL fill_level level=%0d required 15", level); end
    drive(1'b1, 4, rnd_chars(), 1'b0);
    checks++;
    if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready ready=%b required 0", push_ready); end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || level !== LVL_W'(15)) begin
      errors++; $display("FAIL reject overflow=%b level=%0d, required 1 15", overflow, level);
    end
    drive(1'b1, 4, rnd_chars(), 1'b1);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL set_wins overflow=%b required 1", overflow); end
    drive(1'b0, 0, '0, 1'b1);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clear_ovf overflow=%b required 0", overflow); end
    drive(1'b1, 0, rnd_chars(), 1'b0);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || level !== LVL_W'(15)) begin
      errors++; $display("FAIL count0_noop overflow=%b level=%0d, required 0 15", overflow, level);
    end
    drive(1'b1, 7, rnd_chars(), 1'b0);
    checks++;
    if (push_ready !== 1'b0) begin errors++; $display("FAIL clamp_full_ready ready=%b required 0", push_ready); end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL clamp_reject overflow=%b required 1", overflow); end
    drive(1'b0, 0, '0, 1'b1);
    @(negedge clk);
    idle();
    wait_idle(17*FRAME, "overflow");
    drive(1'b1, 7, rnd_chars(), 1'b0);
    checks++;
    if (push_ready !== 1'b1) begin errors++; $display("FAIL clamp_ready ready=%b required 1", push_ready); end
    @(negedge clk);
    idle();
    checks++;
    if (level !== LVL_W'(4)) begin errors++; $display("FAIL clamp_level level=%0d required 4", level); end
    wait_idle(5*FRAME, "clamp");
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 2, rnd_chars(), 1'b0);
    @(negedge clk);
    idle();
    repeat (FRAME) @(negedge clk);
    drive(1'b1, 2, rnd_chars(), 1'b0);
    checks++;
    if (push_ready !== 1'b1) begin errors++; $display("FAIL simul_ready ready=%b required 1", push_ready); end
    @(negedge clk);
    idle();
    checks++;
    if (level !== LVL_W'(2) || tx !== 1'b0) begin
      errors++; $display("FAIL simul_level level=%0d tx=%b, required 2 0", level, tx);
    end
    wait_idle(4*FRAME, "simul");
  endtask

  task automatic test_wrap();
    int sent = 0;
    int cyc = 0;
    int cnt;
    logic v;
    while (sent < 40 && cyc < 4000) begin
      cnt = $urandom_range(1, PUSH_LANES);
      if (cnt > 40 - sent) cnt = 40 - sent;
      v = 1'($urandom_range(0, 1));
      drive(v, cnt, rnd_chars(), 1'b0);
      if (v && push_ready) sent += cnt;
      @(negedge clk);
      cyc++;
    end
    idle();
    checks++;
    if (sent != 40) begin errors++; $display("FAIL wrap_sent sent=%0d required 40", sent); end
    wait_idle(18*FRAME, "wrap");
    drive(1'b0, 0, '0, 1'b1);
    @(negedge clk);
    idle();
    checks++;
    if (level !== '0 || overflow !== 1'b0) begin
      errors++; $display("FAIL wrap_end level=%0d overflow=%b, required 0 0", level, overflow);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] frame;
    drive(1'b1, 1, {7'h05, 21'($urandom)}, 1'b0);
    @(negedge clk);
    idle();
    @(negedge clk);
    repeat (17) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_data_bit3 tx=%b busy=%b, required 0 1", tx, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || level !== '0 || busy !== 1'b0 || overflow !== 1'b0 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset tx=%b level=%0d busy=%b ovf=%b ready=%b, required 1 0 0 0 1",
               tx, level, busy, overflow, push_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    frame = {1'b1, 7'h55, 1'b0};
    drive(1'b1, 1, {7'h55, 21'($urandom)}, 1'b0);
    @(negedge clk);
    idle();
    for (int n = 0; n < FRAME; n++) begin
      @(negedge clk);
      checks++;
      if (tx !== frame[n/CLKS_PER_BIT]) begin
        errors++; $display("FAIL post_reset_frame offset=%0d tx=%b required %b", n, tx, frame[n/CLKS_PER_BIT]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || level !== '0) begin
      errors++; $display("FAIL post_reset_end busy=%b level=%0d, required 0 0", busy, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_lane();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
